serial_frame_tx: RTL and testbench

Serial frame transmitter for the single-bit serial link whose receiver searches the line for the sync pattern 1101. On a start request it latches a parallel payload word and shifts out one bit per clock: the 4-bit sync word 1101, then the payload MSB first. When stuffing is enabled, a 0 is inserted after every transmitted 110 inside the payload, so the sync pattern can never appear in payload data. The block sits between the SAP-1 datapath (payload source) and the serial line.

---
 rtl/serial_frame_pkg.sv | 17 +
 rtl/serial_frame_tx_if.sv | 29 ++
 rtl/frame_stuff_ctl.sv | 38 +++
 rtl/serial_frame_tx.sv | 157 +++++++++++++++
 tb/tb_serial_frame_tx.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame link (transmit and receive sides).
// Holds the sync word, the stuffing pattern and the transmitter state encoding.
package serial_frame_pkg;

    localparam int unsigned     SYNC_W    = 4;
    localparam logic [SYNC_W-1:0] SYNC_WORD = 4'b1101;
    localparam logic [2:0]      STUFF_PAT = 3'b110;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StStuff,
        StDone
    } state_e;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Parallel-side handshake between the payload source and the serial frame transmitter.
interface serial_frame_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              dout;
    logic              frame;
    logic              done;

    modport master (
        output start,
        output data_in,
        input  ready,
        input  dout,
        input  frame,
        input  done
    );

    modport slave (
        input  start,
        input  data_in,
        output ready,
        output dout,
        output frame,
        output done
    );
endinterface

// File: rtl/frame_stuff_ctl.sv
// Tracks the last three bits driven on the line and flags when a stuffed 0 must follow.
module frame_stuff_ctl
    import serial_frame_pkg::*;
#(
    parameter bit STUFF_EN = 1'b1
) (
    input  logic clk,
    input  logic clr,
    input  logic shift_bit,
    input  logic shift_en,
    input  logic hist_clr,
    output logic stuff_req
);

    logic [2:0] hist_q, hist_d;

    // Clear and shift may coincide: the first sync bit lands in a fresh history.
    always_comb begin
        hist_d = hist_q;
        if (hist_clr) begin
            hist_d = 3'b000;
        end
        if (shift_en) begin
            hist_d = {hist_d[1:0], shift_bit};
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hist_q <= 3'b000;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign stuff_req = STUFF_EN && (hist_d == STUFF_PAT);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sends the 1101 sync word, then the payload MSB first,
// optionally inserting a 0 after every 110 so the sync word cannot appear in payload.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter bit          STUFF_EN = 1'b1
) (
    input  logic            clk,
    input  logic            clr,
    serial_frame_tx_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    state_e            state_q, state_d;
    logic [1:0]        sidx_q, sidx_d;
    logic [1:0]        sidx_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              pend_q, pend_d;
    logic              dout_q, dout_d;
    logic              frame_q, frame_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              take_bit, finish;
    logic              shift_en, hist_clr, payload_shift, stuff_req;

    // Registered outputs carry the state being entered, so the bus shows the current state.
    always_comb begin
        state_d       = state_q;
        sidx_d        = sidx_q;
        cnt_d         = cnt_q;
        sh_d          = sh_q;
        dout_d        = 1'b0;
        frame_d       = 1'b0;
        done_d        = 1'b0;
        ready_d       = 1'b0;
        take_bit      = 1'b0;
        finish        = 1'b0;
        shift_en      = 1'b0;
        hist_clr      = 1'b0;
        payload_shift = 1'b0;
        sidx_nxt      = sidx_q + 2'd1;

        case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (bus.start) begin
                    state_d  = StSync;
                    sh_d     = bus.data_in;
                    cnt_d    = '0;
                    sidx_d   = 2'd0;
                    dout_d   = SYNC_WORD[SYNC_W-1];
                    frame_d  = 1'b1;
                    ready_d  = 1'b0;
                    hist_clr = 1'b1;
                    shift_en = 1'b1;
                end
            end
            StSync: begin
                if (sidx_q == 2'(SYNC_W - 1)) begin
                    take_bit = 1'b1;
                end else begin
                    sidx_d   = sidx_nxt;
                    dout_d   = SYNC_WORD[~sidx_nxt];
                    frame_d  = 1'b1;
                    shift_en = 1'b1;
                end
            end
            StData: begin
                if (pend_q) begin
                    state_d  = StStuff;
                    frame_d  = 1'b1;
                    shift_en = 1'b1;
                end else if (cnt_q == CNT_W'(DATA_W)) begin
                    finish = 1'b1;
                end else begin
                    take_bit = 1'b1;
                end
            end
            StStuff: begin
                if (cnt_q == CNT_W'(DATA_W)) begin
                    finish = 1'b1;
                end else begin
                    take_bit = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
        endcase

        if (take_bit) begin
            state_d       = StData;
            dout_d        = sh_q[DATA_W-1];
            sh_d          = sh_q << 1;
            cnt_d         = cnt_q + CNT_W'(1);
            frame_d       = 1'b1;
            shift_en      = 1'b1;
            payload_shift = 1'b1;
        end
        if (finish) begin
            state_d = StDone;
            done_d  = 1'b1;
        end
    end

    frame_stuff_ctl #(
        .STUFF_EN (STUFF_EN)
    ) u_stuff_ctl (
        .clk       (clk),
        .clr       (clr),
        .shift_bit (dout_d),
        .shift_en  (shift_en),
        .hist_clr  (hist_clr),
        .stuff_req (stuff_req)
    );

    // Stuffing is decided only after payload bits, never after sync bits.
    assign pend_d = payload_shift & stuff_req;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            sidx_q  <= 2'd0;
            cnt_q   <= '0;
            sh_q    <= '0;
            pend_q  <= 1'b0;
            dout_q  <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sidx_q  <= sidx_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
            frame_q <= frame_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.frame = frame_q;
    assign bus.done  = done_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: one instance with stuffing, one without,
// fed directed payloads whose line sequences are written out by hand below.
module tb_serial_frame_tx;

    typedef struct {
        logic [31:0] bits;
        int          len;
    } frame_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start_v [2];
    logic [7:0] data_v  [2];
    logic       ready_w [2];
    logic       dout_w  [2];
    logic       frame_w [2];
    logic       done_w  [2];
    bit         gap_chk [2];

    frame_t exp_q0[$];
    frame_t exp_q1[$];
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    serial_frame_tx_if #(.DATA_W(8)) bus_s ();
    serial_frame_tx_if #(.DATA_W(8)) bus_n ();

    assign bus_s.start   = start_v[0];
    assign bus_s.data_in = data_v[0];
    assign bus_n.start   = start_v[1];
    assign bus_n.data_in = data_v[1];
    assign ready_w[0] = bus_s.ready;
    assign dout_w[0]  = bus_s.dout;
    assign frame_w[0] = bus_s.frame;
    assign done_w[0]  = bus_s.done;
    assign ready_w[1] = bus_n.ready;
    assign dout_w[1]  = bus_n.dout;
    assign frame_w[1] = bus_n.frame;
    assign done_w[1]  = bus_n.done;

    serial_frame_tx #(.DATA_W(8), .STUFF_EN(1'b1)) dut_s (
        .clk (clk),
        .clr (clr),
        .bus (bus_s.slave)
    );

    serial_frame_tx #(.DATA_W(8), .STUFF_EN(1'b0)) dut_n (
        .clk (clk),
        .clr (clr),
        .bus (bus_n.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        chk(name, {31'd0, act}, {31'd0, req});
    endtask

    // Hand-derived line sequences: g=0 with stuffing, g=1 without.
    function automatic frame_t lookup(input logic [7:0] d, input int g);
        frame_t s, n;
        s = '{32'd0, 0};
        n = '{32'd0, 0};
        case (d)
            8'h00: begin s = '{32'hD00, 12};                n = '{32'hD00, 12}; end
            8'hC0: begin s = '{32'b1101110000000, 13};      n = '{32'hDC0, 12}; end
            8'hDB: begin s = '{32'b11011100110011, 14};     n = '{32'hDDB, 12}; end
            8'hFF: begin s = '{32'hDFF, 12};                n = '{32'hDFF, 12}; end
            8'h6D: begin s = '{32'b11010110011001, 14};     n = '{32'hD6D, 12}; end
            8'h01: begin s = '{32'hD01, 12};                n = '{32'hD01, 12}; end
            8'hA5: begin s = '{32'b1101100100101, 13};      n = '{32'hDA5, 12}; end
            default: ;
        endcase
        return (g == 0) ? s : n;
    endfunction

    function automatic int qsize(input int g);
        return (g == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic qpop(input int g, output frame_t f);
        if (g == 0) f = exp_q0.pop_front();
        else        f = exp_q1.pop_front();
    endtask

    // Scoreboard feed: an accepted start queues the frame that must follow.
    always @(posedge clk) begin
        if (clr && start_v[0] && ready_w[0]) exp_q0.push_back(lookup(data_v[0], 0));
        if (clr && start_v[1] && ready_w[1]) exp_q1.push_back(lookup(data_v[1], 1));
    end

    task automatic mon(input int g);
        logic [31:0] col = '0;
        logic [31:0] win;
        int          len = 0;
        int          idle_cnt = 0;
        int          hits;
        bit          collecting = 0;
        bit          post = 0;
        frame_t      e;
        forever begin
            @(negedge clk);
            if (!clr) begin
                if (collecting && qsize(g) > 0) qpop(g, e);
                collecting = 0;
                post       = 0;
                idle_cnt   = 0;
                continue;
            end
            if (post) begin
                chk1("ready_after_done", ready_w[g], 1'b1);
                chk1("done_one_cycle", done_w[g], 1'b0);
                post = 0;
            end
            if (frame_w[g]) begin
                if (!collecting) begin
                    if (gap_chk[g]) chk("interframe_gap", idle_cnt, 32'd2);
                    collecting = 1;
                    col        = '0;
                    len        = 0;
                end
                chk1("ready_low_in_frame", ready_w[g], 1'b0);
                col = {col[30:0], dout_w[g]};
                len++;
            end else if (collecting) begin
                collecting = 0;
                post       = 1;
                idle_cnt   = 1;
                chk1("done_pulse", done_w[g], 1'b1);
                if (qsize(g) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: dut %0d sent %0d bits %0h, none expected",
                             g, len, col);
                end else begin
                    qpop(g, e);
                    chk("frame_len", len, e.len);
                    chk("frame_bits", col, e.bits);
                    if (g == 0) begin
                        hits = 0;
                        for (int i = 0; i + 4 <= len; i++) begin
                            win = col >> (len - 4 - i);
                            if (win[3:0] == 4'b1101) hits++;
                        end
                        chk("sync_detect_count", hits, 32'd1);
                    end
                end
            end else begin
                idle_cnt++;
                chk1("dout_idle", dout_w[g], 1'b0);
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    task automatic wait_ready(input int g);
        int n = 0;
        while (!ready_w[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_w[g]) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: dut %0d ready=%0b after %0d cycles, expected 1", g,
                     ready_w[g], n);
        end
    endtask

    // Starts both instances on the same edge; poke=1 also fires start pulses mid-frame.
    task automatic send_both(input logic [7:0] d, input bit poke);
        wait_ready(0);
        wait_ready(1);
        data_v[0]  = d;
        data_v[1]  = d;
        start_v[0] = 1'b1;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        data_v[0]  = 8'h3C;
        data_v[1]  = 8'h3C;
        if (poke) begin
            repeat (3) @(negedge clk);
            start_v[0] = 1'b1;
            start_v[1] = 1'b1;
            @(negedge clk);
            start_v[0] = 1'b0;
            start_v[1] = 1'b0;
            @(negedge clk);
            start_v[0] = 1'b1;
            start_v[1] = 1'b1;
            data_v[0]  = 8'h00;
            data_v[1]  = 8'h00;
            @(negedge clk);
            start_v[0] = 1'b0;
            start_v[1] = 1'b0;
        end
    endtask

    task automatic b2b(input int g);
        logic [7:0] seq [3];
        seq[0] = 8'hFF;
        seq[1] = 8'h6D;
        seq[2] = 8'h01;
        wait_ready(g);
        start_v[g] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ready(g);
            if (i == 1) gap_chk[g] = 1'b1;
            data_v[g] = seq[i];
            @(negedge clk);
            data_v[g] = 8'h5A;
        end
        start_v[g] = 1'b0;
        wait_ready(g);
        gap_chk[g] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        start_v[0] = 1'b1;
        start_v[1] = 1'b1;
        data_v[0]  = 8'h00;
        data_v[1]  = 8'h00;
        gap_chk[0] = 1'b0;
        gap_chk[1] = 1'b0;

        // Reset held with start asserted: outputs must stay idle.
        repeat (5) begin
            @(negedge clk);
            data_v[0] = 8'($urandom);
            data_v[1] = 8'($urandom);
            for (int g = 0; g < 2; g++) begin
                chk1("rst_dout", dout_w[g], 1'b0);
                chk1("rst_frame", frame_w[g], 1'b0);
                chk1("rst_done", done_w[g], 1'b0);
                chk1("rst_ready", ready_w[g], 1'b1);
            end
        end
        data_v[0] = 8'h00;
        data_v[1] = 8'h00;
        clr       = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;

        send_both(8'hC0, 1'b0);
        send_both(8'hDB, 1'b1);

        fork
            b2b(0);
            b2b(1);
        join

        // Abort a frame during payload bit 5, then send a clean frame.
        send_both(8'hDB, 1'b0);
        repeat (8) @(posedge clk);
        #2 clr = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk1("abort_dout", dout_w[g], 1'b0);
            chk1("abort_frame", frame_w[g], 1'b0);
            chk1("abort_done", done_w[g], 1'b0);
            chk1("abort_ready", ready_w[g], 1'b1);
        end
        @(negedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        send_both(8'hA5, 1'b0);

        wait_ready(0);
        wait_ready(1);
        repeat (3) @(negedge clk);
        chk("queue0_drained", qsize(0), 32'd0);
        chk("queue1_drained", qsize(1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
